uart_rx_param: RTL and testbench

Parametrised UART receiver and successor to the fixed 8N1 receiver in the UART-to-LCD path.
- Configurable data width, parity, stop bits and oversampling.
- Input synchroniser plus 3-sample majority vote per bit.
- Start-glitch rejection.
- Framing, parity and overrun error reporting.
- Valid/ready output holding register, so the LCD writer or a FIFO can back-pressure.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_baud_tick.sv | 38 +++
 rtl/uart_rx_param.sv | 191 +++++++++++++++++++
 tb/tb_uart_rx_param.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART: FSM encoding, parity modes, baud divider math.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  function automatic int calc_div(input int clk_hz, input int baud, input int oversample);
    return clk_hz / (baud * oversample);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: free-running divider, one-clk tick every DIV clocks.
// No backpressure; tick is combinational from the counter and never stalls.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  generate
    if (DIV < 2) begin : g_div_check
      $error("uart_baud_tick: CLK_HZ/(BAUD*OVERSAMPLE) must be at least 2");
    end
  endgenerate

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt == CW'(DIV - 1)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == CW'(DIV - 1));

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-FF sync, 3-sample majority per bit, result one clk after last-stop decision.
// Single holding register with valid/ready; a frame completing while it is full is dropped with overrun_err.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] dout,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun_err,
  output logic                 busy
);

  generate
    if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_os_check
      $error("uart_rx_param: OVERSAMPLE must be even and >= 8");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_db_check
      $error("uart_rx_param: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_par_check
      $error("uart_rx_param: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_stop_check
      $error("uart_rx_param: STOP_BITS must be 1 or 2");
    end
  endgenerate

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int NW = $clog2(DATA_BITS);
  localparam logic [SW-1:0] S_SMP_A = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_SMP_B = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_DEC   = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] S_LAST  = SW'(OVERSAMPLE - 1);
  localparam logic [NW-1:0] N_LAST  = NW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS == 2);

  logic rx_meta, rx_s;
  logic tick;

  state_t               state;
  logic [SW-1:0]        s;
  logic [NW-1:0]        n;
  logic [DATA_BITS-1:0] shreg;
  logic                 smp_a, smp_b;
  logic                 stop_n;
  logic                 fe_acc, pe_acc;
  logic                 done;
  logic                 armed;
  logic                 bit_v;
  logic                 decide;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  uart_baud_tick #(
    .CLK_HZ    (CLK_HZ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_baud_tick (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  // Third sample is the live rx_s on the decision tick itself.
  assign bit_v  = (smp_a & smp_b) | (smp_a & rx_s) | (smp_b & rx_s);
  assign decide = tick && (s == S_DEC);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      s      <= '0;
      n      <= '0;
      shreg  <= '0;
      smp_a  <= 1'b1;
      smp_b  <= 1'b1;
      stop_n <= 1'b0;
      fe_acc <= 1'b0;
      pe_acc <= 1'b0;
      done   <= 1'b0;
      armed  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (tick && state != S_IDLE) begin
        s <= (s == S_LAST) ? '0 : s + SW'(1);
        if (s == S_SMP_A) smp_a <= rx_s;
        if (s == S_SMP_B) smp_b <= rx_s;
      end
      case (state)
        S_IDLE: begin
          // Line must be seen high before a new start is honoured (break recovery).
          if (rx_s) armed <= 1'b1;
          if (tick && !rx_s && armed) begin
            s      <= '0;
            fe_acc <= 1'b0;
            pe_acc <= 1'b0;
            state  <= S_START;
          end
        end
        S_START: begin
          if (decide && bit_v) begin
            state <= S_IDLE;
          end else if (tick && s == S_LAST) begin
            n     <= '0;
            state <= S_DATA;
          end
        end
        S_DATA: begin
          if (decide) shreg <= {bit_v, shreg[DATA_BITS-1:1]};
          if (tick && s == S_LAST) begin
            if (n == N_LAST) begin
              stop_n <= 1'b0;
              state  <= (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
            end else begin
              n <= n + NW'(1);
            end
          end
        end
        S_PARITY: begin
          if (decide) begin
            pe_acc <= (PARITY == PAR_ODD) ? ~(^shreg ^ bit_v) : (^shreg ^ bit_v);
          end
          if (tick && s == S_LAST) begin
            stop_n <= 1'b0;
            state  <= S_STOP;
          end
        end
        S_STOP: begin
          if (decide) begin
            if (!bit_v) fe_acc <= 1'b1;
            // Leave at mid-bit of the last stop so the next start edge is caught early.
            if (stop_n == STOP_LAST) begin
              done  <= 1'b1;
              armed <= 1'b0;
              state <= S_IDLE;
            end
          end else if (tick && s == S_LAST) begin
            stop_n <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout        <= '0;
      dout_valid  <= 1'b0;
      frame_err   <= 1'b0;
      parity_err  <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      overrun_err <= 1'b0;
      if (done) begin
        if (!dout_valid || dout_ready) begin
          dout       <= shreg;
          frame_err  <= fe_acc;
          parity_err <= pe_acc;
          dout_valid <= 1'b1;
        end else begin
          overrun_err <= 1'b1;
        end
      end else if (dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
      end
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three configurations (8N1, 8E1, 7O2) driven with random frames against a frame-level model.
module tb_uart_rx_param;

  localparam int BIT_CLKS = 160;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst [3];
  logic rx  [3];
  logic rdy [3];
  logic vld [3];
  logic fe  [3];
  logic pe  [3];
  logic ov  [3];
  logic bsy [3];
  logic [7:0] d0, d1;
  logic [6:0] d2;

  uart_rx_param #(.CLK_HZ(1600000), .BAUD(10000), .OVERSAMPLE(16),
                  .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst(rst[0]), .rx(rx[0]), .dout(d0), .dout_valid(vld[0]),
    .dout_ready(rdy[0]), .frame_err(fe[0]), .parity_err(pe[0]),
    .overrun_err(ov[0]), .busy(bsy[0]));

  uart_rx_param #(.CLK_HZ(1600000), .BAUD(10000), .OVERSAMPLE(16),
                  .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .rst(rst[1]), .rx(rx[1]), .dout(d1), .dout_valid(vld[1]),
    .dout_ready(rdy[1]), .frame_err(fe[1]), .parity_err(pe[1]),
    .overrun_err(ov[1]), .busy(bsy[1]));

  uart_rx_param #(.CLK_HZ(1600000), .BAUD(10000), .OVERSAMPLE(16),
                  .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_7o2 (
    .clk(clk), .rst(rst[2]), .rx(rx[2]), .dout(d2), .dout_valid(vld[2]),
    .dout_ready(rdy[2]), .frame_err(fe[2]), .parity_err(pe[2]),
    .overrun_err(ov[2]), .busy(bsy[2]));

  function automatic int nbits(input int u);
    return (u == 2) ? 7 : 8;
  endfunction

  function automatic int pmode(input int u);
    return (u == 1) ? 2 : ((u == 2) ? 1 : 0);
  endfunction

  function automatic int nstop(input int u);
    return (u == 2) ? 2 : 1;
  endfunction

  function automatic logic [8:0] dq(input int u);
    if (u == 0) return {1'b0, d0};
    if (u == 1) return {1'b0, d1};
    return {2'b00, d2};
  endfunction

  // Accepted words, tagged {instance, frame_err, parity_err, data}.
  logic [12:0] got[$];
  int vcnt [3];
  int ovc  [3];
  int bcnt [3];

  always @(negedge clk) begin
    for (int u = 0; u < 3; u++) begin
      if (vld[u] === 1'b1 && rdy[u] === 1'b1) got.push_back({2'(u), fe[u], pe[u], dq(u)});
      if (vld[u] === 1'b1) vcnt[u]++;
      if (ov[u] === 1'b1)  ovc[u]++;
      if (bsy[u] === 1'b1) bcnt[u]++;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  // pb: 0/1 forces the parity bit, 2 sends the correct one. stops[i] is the value of stop bit i.
  // cut != 0 abandons the frame before bit index cut. Returns the word the receiver should deliver.
  task automatic send(input int u, input logic [8:0] d, input int pb, input logic [1:0] stops,
                      input bit noise, input int cut, output logic [12:0] w);
    logic b[$];
    logic [8:0] dm;
    logic pbit, fe_e, pe_e;
    int nb, ndata, off;
    nb   = nbits(u);
    dm   = d & ((9'd1 << nb) - 9'd1);
    fe_e = 1'b0;
    pe_e = 1'b0;
    b.push_back(1'b0);
    for (int i = 0; i < nb; i++) b.push_back(dm[i]);
    if (pmode(u) != 0) begin
      if (pb == 2) pbit = (pmode(u) == 1) ? ~(^dm) : (^dm);
      else         pbit = pb[0];
      pe_e = (pmode(u) == 1) ? ((^dm ^ pbit) == 1'b0) : ((^dm ^ pbit) == 1'b1);
      b.push_back(pbit);
    end
    ndata = b.size();
    for (int i = 0; i < nstop(u); i++) begin
      b.push_back(stops[i]);
      if (!stops[i]) fe_e = 1'b1;
    end
    w = {2'(u), fe_e, pe_e, dm};
    for (int i = 0; i < b.size(); i++) begin
      if (cut != 0 && i == cut) return;
      off = $urandom_range(40, 120);
      for (int c = 0; c < BIT_CLKS; c++) begin
        rx[u] = b[i] ^ (noise && i < ndata && c == off);
        step(1);
      end
    end
    rx[u] = 1'b1;
    step(BIT_CLKS);
  endtask

  task automatic expect_next(input string tag, input logic [12:0] w);
    int t;
    t = 0;
    while (got.size() == 0 && t < 600) begin
      step(1);
      t++;
    end
    chk({tag, "_present"}, 32'(got.size() > 0), 1);
    if (got.size() > 0) chk(tag, got.pop_front(), w);
  endtask

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [12:0] w, w1, w2;
    int v0, o0, b0;
    for (int u = 0; u < 3; u++) begin
      rst[u] = 1'b1;
      rx[u]  = 1'b1;
      rdy[u] = 1'b1;
    end
    step(5);
    for (int u = 0; u < 3; u++)
      chk($sformatf("reset_u%0d", u), {vld[u], fe[u], pe[u], ov[u], bsy[u], dq(u)}, 0);
    for (int u = 0; u < 3; u++) rst[u] = 1'b0;
    step(20);

    // 8N1 basic and random frames
    v0 = vcnt[0];
    send(0, 9'h55, 2, 2'b11, 0, 0, w);
    expect_next("t1_frame", w);
    chk("t1_valid_pulse", vcnt[0] - v0, 1);
    chk("t1_busy_low", bsy[0], 0);
    for (int k = 0; k < 5; k++) begin
      send(0, 9'($urandom), 2, ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b11, 0, 0, w);
      expect_next("rand_u0", w);
    end

    // even parity
    send(1, 9'h0A3, 1, 2'b11, 0, 0, w);
    expect_next("t2_bad_parity", w);
    send(1, 9'h0A3, 0, 2'b11, 0, 0, w);
    expect_next("t2_good_parity", w);
    for (int k = 0; k < 5; k++) begin
      send(1, 9'($urandom), $urandom_range(0, 2), 2'b11, 0, 0, w);
      expect_next("rand_u1", w);
    end

    // start glitch
    b0 = bcnt[0];
    rx[0] = 1'b0;
    step(40);
    rx[0] = 1'b1;
    step(300);
    chk("t3_no_frame", got.size(), 0);
    chk("t3_busy_seen", 32'((bcnt[0] - b0) > 0), 1);
    chk("t3_idle", bsy[0], 0);
    send(0, 9'h03C, 2, 2'b11, 0, 0, w);
    expect_next("t3_after_glitch", w);

    // framing error then clean frame
    send(0, 9'h081, 2, 2'b10, 0, 0, w);
    expect_next("t4_frame_err", w);
    step(10 * BIT_CLKS);
    send(0, 9'h07E, 2, 2'b11, 0, 0, w);
    expect_next("t4_clean", w);

    // overrun with consumer stalled
    rdy[0] = 1'b0;
    o0 = ovc[0];
    send(0, 9'h011, 2, 2'b11, 0, 0, w1);
    send(0, 9'h022, 2, 2'b11, 0, 0, w2);
    chk("t5_overrun_pulses", ovc[0] - o0, 1);
    chk("t5_hold", {vld[0], fe[0], pe[0], dq(0)}, {1'b1, w1[10:0]});
    chk("t5_not_accepted", got.size(), 0);
    rdy[0] = 1'b1;
    step(1);
    chk("t5_valid_drop", vld[0], 0);
    expect_next("t5_frame", w1);

    // break: one zero frame with framing error, no retrigger while line stays low
    rx[0] = 1'b0;
    step(12 * BIT_CLKS);
    rx[0] = 1'b1;
    step(2 * BIT_CLKS);
    expect_next("brk_frame", {2'd0, 1'b1, 1'b0, 9'h000});
    chk("brk_single", got.size(), 0);
    send(0, 9'h033, 2, 2'b11, 0, 0, w);
    expect_next("brk_recover", w);

    // 7O2 with single-clk noise
    send(2, 9'h05A, 2, 2'b11, 1, 0, w);
    expect_next("t6_noise_5a", w);
    send(2, 9'h05A, 2, 2'b01, 0, 0, w);
    expect_next("t6_stop2_bad", w);
    send(2, 9'h05A, 2, 2'b10, 0, 0, w);
    expect_next("t6_stop1_bad", w);
    for (int k = 0; k < 3; k++) begin
      send(2, 9'($urandom), $urandom_range(0, 2), 2'b11, 1, 0, w);
      expect_next("rand_u2", w);
    end

    // reset mid-frame
    send(2, 9'h07F, 2, 2'b11, 0, 5, w);
    chk("t6_busy_mid", bsy[2], 1);
    rst[2] = 1'b1;
    rx[2]  = 1'b1;
    step(3);
    chk("t6_reset_outputs", {vld[2], fe[2], pe[2], ov[2], bsy[2], dq(2)}, 0);
    rst[2] = 1'b0;
    step(300);
    chk("t6_no_partial", got.size(), 0);
    send(2, 9'h012, 2, 2'b11, 0, 0, w);
    expect_next("t6_after_reset", w);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
